// File: rtl/bullet_pool_ctl_pkg.sv
// Shared game constants and types for the bullet pool.
// Imported by the pool controller, its interface and the slot finder.
package bullet_pool_ctl_pkg;

  localparam int DEF_HOR_PIXELS    = 1024;
  localparam int DEF_VER_PIXELS    = 768;
  localparam int DEF_PLAYER_WIDTH  = 64;
  localparam int DEF_PLAYER_HEIGHT = 64;
  localparam int DEF_BULLET_WIDTH  = 16;
  localparam int DEF_BULLET_HEIGHT = 32;
  localparam int DEF_BULLET_SPEED  = 6;
  localparam int DEF_FIRE_COOLDOWN = 8;
  localparam int DEF_SLOTS         = 4;
  localparam int CD_W              = 8;

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    SPAWN
  } bullet_fsm_t;

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bullet_pool_ctl_if.sv
// Control/status bundle between game logic and the bullet pool.
// master drives requests, slave is the pool controller.
interface bullet_pool_ctl_if
  import bullet_pool_ctl_pkg::*;
#(
  parameter int SLOTS = DEF_SLOTS
);

  localparam int IW = idx_w(SLOTS);

  logic              frame_tick;
  logic              fire;
  logic [11:0]       player_xpos;
  logic              hit_valid;
  logic [IW-1:0]     hit_slot;
  logic [SLOTS-1:0]  active;
  logic [SLOTS*12-1:0] bullet_x;
  logic [SLOTS*12-1:0] bullet_y;
  logic              fire_ack;
  logic              busy;

  modport master (
    output frame_tick, fire, player_xpos,
    output hit_valid, hit_slot,
    input  active, bullet_x, bullet_y,
    input  fire_ack, busy
  );

  modport slave (
    input  frame_tick, fire, player_xpos,
    input  hit_valid, hit_slot,
    output active, bullet_x, bullet_y,
    output fire_ack, busy
  );

endinterface

// File: rtl/bullet_pool_ctl_free_slot_finder.sv
// Lowest-index free slot over the active mask.
// Purely combinational priority encoder.
module free_slot_finder
  import bullet_pool_ctl_pkg::*;
#(
  parameter int SLOTS = DEF_SLOTS,
  parameter int IW    = idx_w(SLOTS)
)(
  input  logic [SLOTS-1:0] active,
  output logic [IW-1:0]    free_idx,
  output logic             any_free
);

  // scan high to low so the lowest free index is written last
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!active[i]) begin
        free_idx = IW'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bullet_pool_ctl.sv
// Player projectile pool: per-frame step, retire, spawn.
// Hits from collision logic retire slots at any time.
module bullet_pool_ctl
  import bullet_pool_ctl_pkg::*;
#(
  parameter int SLOTS         = DEF_SLOTS,
  parameter int BULLET_WIDTH  = DEF_BULLET_WIDTH,
  parameter int BULLET_HEIGHT = DEF_BULLET_HEIGHT,
  parameter int PLAYER_WIDTH  = DEF_PLAYER_WIDTH,
  parameter int BULLET_SPEED  = DEF_BULLET_SPEED,
  parameter int START_Y       = DEF_VER_PIXELS
                                - DEF_PLAYER_HEIGHT
                                - BULLET_HEIGHT,
  parameter int FIRE_COOLDOWN = DEF_FIRE_COOLDOWN
)(
  input  logic clk,
  input  logic rst,
  bullet_pool_ctl_if.slave bus
);

  localparam int IW = idx_w(SLOTS);
  localparam logic [11:0] X_OFS =
    12'((PLAYER_WIDTH - BULLET_WIDTH) / 2);
  localparam logic [11:0] SPEED = 12'(BULLET_SPEED);
  localparam logic [11:0] Y0    = 12'(START_Y);
  localparam logic [CD_W-1:0] CD0 = CD_W'(FIRE_COOLDOWN);
  localparam logic [IW-1:0] LAST = IW'(SLOTS - 1);

  bullet_fsm_t state, state_n;

  logic [IW-1:0]          idx_q, idx_n;
  logic [SLOTS-1:0]       act_q, act_n;
  logic [SLOTS-1:0][11:0] x_q, x_n;
  logic [SLOTS-1:0][11:0] y_q, y_n;
  logic                   ack_q, ack_n;
  logic                   busy_q;
  logic                   pend_q, pend_n;
  logic                   prev_q;
  logic [CD_W-1:0]        cd_q, cd_n;
  logic [IW-1:0]          free_idx;
  logic                   any_free;
  logic                   rise;
  logic                   hit_ok;
  logic                   hit_here;

  assign rise   = bus.fire & ~prev_q;
  assign hit_ok = bus.hit_valid
                  && (32'(bus.hit_slot) < SLOTS);

  free_slot_finder #(.SLOTS(SLOTS)) u_find (
    .active   (act_q),
    .free_idx (free_idx),
    .any_free (any_free)
  );

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // sequence: idle -> one cycle per slot -> spawn
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (bus.frame_tick) state_n = UPDATE;
      UPDATE:  if (idx_q == LAST) state_n = SPAWN;
      SPAWN:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // next pool contents; hit beats step, spawn beats hit
  always_comb begin
    idx_n    = '0;
    act_n    = act_q;
    x_n      = x_q;
    y_n      = y_q;
    ack_n    = 1'b0;
    pend_n   = pend_q | rise;
    cd_n     = cd_q;
    hit_here = hit_ok && (bus.hit_slot == idx_q);
    if (state == UPDATE) begin
      if (idx_q != LAST) idx_n = idx_q + IW'(1);
      if (act_q[idx_q] && !hit_here) begin
        if (y_q[idx_q] < SPEED) act_n[idx_q] = 1'b0;
        else y_n[idx_q] = y_q[idx_q] - SPEED;
      end
    end
    if (hit_ok) act_n[bus.hit_slot] = 1'b0;
    if (state == SPAWN) begin
      if (cd_q != '0) begin
        cd_n = cd_q - CD_W'(1);
      end else if (pend_q && any_free) begin
        act_n[free_idx] = 1'b1;
        x_n[free_idx]   = bus.player_xpos + X_OFS;
        y_n[free_idx]   = Y0;
        ack_n           = 1'b1;
        pend_n          = rise;
        cd_n            = CD0;
      end
    end
  end

  // registered pool state and outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q  <= '0;
      act_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      ack_q  <= 1'b0;
      busy_q <= 1'b0;
      pend_q <= 1'b0;
      prev_q <= 1'b0;
      cd_q   <= '0;
    end else begin
      idx_q  <= idx_n;
      act_q  <= act_n;
      x_q    <= x_n;
      y_q    <= y_n;
      ack_q  <= ack_n;
      busy_q <= (state_n != IDLE);
      pend_q <= pend_n;
      prev_q <= bus.fire;
      cd_q   <= cd_n;
    end
  end

  assign bus.active   = act_q;
  assign bus.bullet_x = x_q;
  assign bus.bullet_y = y_q;
  assign bus.fire_ack = ack_q;
  assign bus.busy     = busy_q;

endmodule

// File: doc/bullet_pool_ctl.md
Name: bullet_pool_ctl

Overview:
Manages a pool of player projectiles so several bullets can be in flight at once. It replaces the single-bullet logic in the player controller.
- Once per frame it steps every active slot upward, retires slots that leave the screen, and allocates a free slot on a fire request.
- It clears slots on hit reports from collision logic.
- Sits between keyboard_ctl/player position and the projectile draw chain; per-slot positions and the active mask feed the draw_rect instances.

Parameters:
SLOTS, 4, number of bullet slots (2..8)
BULLET_WIDTH, 16, projectile sprite width in px
BULLET_HEIGHT, 32, projectile sprite height in px
PLAYER_WIDTH, 64, player sprite width in px
BULLET_SPEED, 6, px moved up per frame
START_Y, VER_PIXELS-64-BULLET_HEIGHT, spawn y (top edge of bullet)
FIRE_COOLDOWN, 8, frames between accepted shots (0 = none)

Ports:
clk  in  1  65 MHz pixel clock
rst  in  1  asynchronous, active-low reset
frame_tick  in  1  one-cycle pulse, once per frame (start of vblank)
fire  in  1  shoot button level from keyboard_ctl
player_xpos  in  12  player left x
hit_valid  in  1  hit report strobe
hit_slot  in  $clog2(SLOTS)  slot to retire on hit
active  out  SLOTS  per-slot active flag
bullet_x  out  SLOTS*12  packed x per slot; slot i at [12*i +: 12]
bullet_y  out  SLOTS*12  packed y per slot, same packing
fire_ack  out  1  one-cycle pulse when a bullet is spawned
busy  out  1  high while the frame update sequence runs

Behaviour:
- Reset (async, rst=0): active=0, all bullet_x/bullet_y=0, fire_ack=0, busy=0, cooldown=0, fire_pending=0, fire_prev=0, state IDLE. All outputs are registered.
- Fire detect:
  - fire registered into fire_prev; rising edge (fire & ~fire_prev) sets fire_pending.
  - Holding fire gives exactly one request; release and re-press is required for the next.
  - fire_pending is sticky until a spawn succeeds.
- FSM states IDLE, UPDATE, SPAWN.
  - IDLE: frame_tick -> UPDATE with idx=0, busy=1 from the next cycle. frame_tick outside IDLE is ignored.
  - UPDATE: one slot per cycle (idx 0..SLOTS-1).
    - If active[idx] and bullet_y[idx] < BULLET_SPEED: clear active[idx]; y holds.
    - Else if active[idx]: y -= BULLET_SPEED.
    - Inactive slots are untouched.
    - After idx=SLOTS-1 -> SPAWN.
  - SPAWN (one cycle):
    - cooldown != 0: decrement it, no spawn.
    - Else if fire_pending and any slot is free: lowest-index free slot gets x = player_xpos + (PLAYER_WIDTH-BULLET_WIDTH)/2 and y = START_Y; set active, pulse fire_ack, clear fire_pending, load cooldown = FIRE_COOLDOWN.
    - If no slot is free, fire_pending is retained for the next frame.
    - Then -> IDLE, busy=0.
- Latency: frame_tick at cycle T; UPDATE occupies T+1..T+SLOTS; SPAWN at T+SLOTS+1; fire_ack and new positions visible at T+SLOTS+2.
- Hits: hit_valid in any state clears active[hit_slot] the following cycle.
  - Hit on an inactive slot is ignored.
  - Hit and UPDATE on the same slot in the same cycle: hit wins, slot inactive, y unchanged.
  - Hit on the slot being allocated in SPAWN: the slot was free, so the hit is ignored and the spawn wins.
  - hit_slot >= SLOTS is ignored.
- Arithmetic: 12-bit unsigned. The spawn x sum does not wrap for player_xpos <= HOR_PIXELS-PLAYER_WIDTH.
- Reset mid-sequence returns to IDLE with the pool empty; no partial update survives.

Decomposition:
- game_pkg (new, alongside vga_pkg): typedef enum bullet_fsm_t {IDLE, UPDATE, SPAWN}; shared constants PLAYER_WIDTH/HEIGHT, BULLET_WIDTH/HEIGHT, BULLET_SPEED. top_vga uses the same constants.
- One sub-module, free_slot_finder: combinational priority encoder over ~active giving lowest free index plus any_free.

Test Plan:
- Reset: rst=0 mid-UPDATE with 2 active slots -> active=0, busy=0, positions 0, state IDLE immediately.
- Single shot (FIRE_COOLDOWN=0, player_xpos=100): fire rising edge, frame_tick at T -> fire_ack at T+SLOTS+2, slot0 x=124, y=672. Next frame_tick -> y=666.
- Hold fire across 5 frames -> exactly one fire_ack. Release and press -> second shot in slot1.
- Pool full (SLOTS=4, cooldown 0): 5 press/release/frame cycles -> slots 0..3 active, no 5th fire_ack, fire_pending stays set. Hit on slot2 -> next frame spawns into slot2.
- Top exit: slot0 y=5 at frame_tick -> active[0]=0 after its UPDATE cycle. Slot with y=6 -> y=0 and still active.
- Cooldown=8: two presses in consecutive frames -> second fire_ack exactly 9 frame_ticks after the first.
- Simultaneous: hit_valid with hit_slot=1 on slot1's UPDATE cycle -> active[1]=0, y unchanged. frame_tick during busy -> ignored, no extra step.
